// File: rtl/nec_ir_pkg.sv
// Shared NEC infrared definitions: default timing counts (50 MHz clock),
// receiver decision thresholds, transmitter state codes and frame assembly.
package nec_ir_pkg;

    // Every duration counter in the IR blocks uses this width (fits GAP).
    localparam int CNT_W = 22;

    // Default phase lengths in clk cycles at 50 MHz.
    localparam int DEF_LEADER_MARK  = 450000;   // 9 ms
    localparam int DEF_LEADER_SPACE = 225000;   // 4.5 ms
    localparam int DEF_REPEAT_SPACE = 112500;   // 2.25 ms
    localparam int DEF_BIT_MARK     = 28125;    // 562.5 us
    localparam int DEF_ZERO_SPACE   = 28125;    // 562.5 us
    localparam int DEF_ONE_SPACE    = 84375;    // 1687.5 us
    localparam int DEF_GAP          = 2000000;  // 40 ms
    localparam int DEF_CARRIER_HALF = 658;      // ~38 kHz carrier

    // Receiver thresholds: midpoints between the two legal lengths.
    localparam int DEF_LEADER_SPACE_THRESHOLD = (DEF_LEADER_SPACE + DEF_REPEAT_SPACE) / 2;
    localparam int DEF_BIT_THRESHOLD          = (DEF_ZERO_SPACE + DEF_ONE_SPACE) / 2;
    localparam int DEF_LEADER_MARK_MIN        = (DEF_LEADER_MARK * 3) / 4;

    // Transmitter state codes.
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LEAD_MARK  = 3'd1;
    localparam logic [2:0] ST_LEAD_SPACE = 3'd2;
    localparam logic [2:0] ST_REP_SPACE  = 3'd3;
    localparam logic [2:0] ST_BIT_MARK   = 3'd4;
    localparam logic [2:0] ST_BIT_SPACE  = 3'd5;
    localparam logic [2:0] ST_STOP_MARK  = 3'd6;
    localparam logic [2:0] ST_GAP        = 3'd7;

    // On-air word, transmitted bit 0 first.
    function automatic logic [31:0] nec_frame(input logic [15:0] address,
                                              input logic [7:0]  command);
        return {~command, command, address[15:8], address[7:0]};
    endfunction

endpackage

// File: rtl/nec_ir_tx_if.sv
// Request/status bundle between a client and the NEC transmitter.
interface nec_ir_tx_if;

    logic        start;
    logic        repeat_req;
    logic [15:0] address;
    logic [7:0]  command;
    logic        ir_line;
    logic        ir_led;
    logic        busy;
    logic        done;

    modport master (
        output start, repeat_req, address, command,
        input  ir_line, ir_led, busy, done
    );

    modport slave (
        input  start, repeat_req, address, command,
        output ir_line, ir_led, busy, done
    );

endinterface

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier that runs only while enabled. Each enable rise
// restarts it at phase 1, so every burst opens with a full high half-period.
module ir_carrier_gen
    import nec_ir_pkg::*;
#(
    parameter int CARRIER_HALF = DEF_CARRIER_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic carrier
);

    logic             enable_q;
    logic [CNT_W-1:0] half_cnt;

    // Half-period divider: held cleared while disabled, reloaded on enable rise.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            enable_q <= 1'b0;
            half_cnt <= '0;
            carrier  <= 1'b0;
        end else begin
            enable_q <= enable;
            if (!enable) begin
                half_cnt <= '0;
                carrier  <= 1'b0;
            end else if (!enable_q) begin
                half_cnt <= CNT_W'(CARRIER_HALF - 1);
                carrier  <= 1'b1;
            end else if (half_cnt == '0) begin
                half_cnt <= CNT_W'(CARRIER_HALF - 1);
                carrier  <= ~carrier;
            end else begin
                half_cnt <= half_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: serialises a latched 32-bit frame or a repeat
// code onto a registered line level, with a carrier-gated LED drive.
module nec_ir_tx
    import nec_ir_pkg::*;
#(
    parameter int LEADER_MARK  = DEF_LEADER_MARK,
    parameter int LEADER_SPACE = DEF_LEADER_SPACE,
    parameter int REPEAT_SPACE = DEF_REPEAT_SPACE,
    parameter int BIT_MARK     = DEF_BIT_MARK,
    parameter int ZERO_SPACE   = DEF_ZERO_SPACE,
    parameter int ONE_SPACE    = DEF_ONE_SPACE,
    parameter int GAP          = DEF_GAP,
    parameter int CARRIER_HALF = DEF_CARRIER_HALF
) (
    input  logic       clk,
    input  logic       rst,
    nec_ir_tx_if.slave bus
);

    logic [2:0]       state_q,  state_n;
    logic [CNT_W-1:0] cnt_q,    cnt_n;
    logic [5:0]       bit_q,    bit_n;
    logic [31:0]      data_q,   data_n;
    logic             rep_q,    rep_n;
    logic             line_q,   line_n;
    logic             busy_q,   busy_n;
    logic             done_q,   done_n;
    logic             carrier;

    // Next-state, next-line and duration-counter reload decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_n = state_q;
        cnt_n   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        bit_n   = bit_q;
        data_n  = data_q;
        rep_n   = rep_q;
        line_n  = line_q;
        busy_n  = busy_q;
        done_n  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n = ST_LEAD_MARK;
                    cnt_n   = CNT_W'(LEADER_MARK - 1);
                    bit_n   = '0;
                    data_n  = nec_frame(bus.address, bus.command);
                    rep_n   = bus.repeat_req;
                    line_n  = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            ST_LEAD_MARK: begin
                if (cnt_q == '0) begin
                    line_n = 1'b1;
                    if (rep_q) begin
                        state_n = ST_REP_SPACE;
                        cnt_n   = CNT_W'(REPEAT_SPACE - 1);
                    end else begin
                        state_n = ST_LEAD_SPACE;
                        cnt_n   = CNT_W'(LEADER_SPACE - 1);
                    end
                end
            end
            ST_LEAD_SPACE: begin
                if (cnt_q == '0) begin
                    state_n = ST_BIT_MARK;
                    cnt_n   = CNT_W'(BIT_MARK - 1);
                    line_n  = 1'b0;
                end
            end
            ST_REP_SPACE: begin
                if (cnt_q == '0) begin
                    state_n = ST_STOP_MARK;
                    cnt_n   = CNT_W'(BIT_MARK - 1);
                    line_n  = 1'b0;
                end
            end
            ST_BIT_MARK: begin
                if (cnt_q == '0) begin
                    state_n = ST_BIT_SPACE;
                    cnt_n   = data_q[bit_q[4:0]] ? CNT_W'(ONE_SPACE - 1)
                                                 : CNT_W'(ZERO_SPACE - 1);
                    line_n  = 1'b1;
                end
            end
            ST_BIT_SPACE: begin
                if (cnt_q == '0) begin
                    state_n = (bit_q == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                    cnt_n   = CNT_W'(BIT_MARK - 1);
                    bit_n   = bit_q + 6'd1;
                    line_n  = 1'b0;
                end
            end
            ST_STOP_MARK: begin
                if (cnt_q == '0) begin
                    state_n = ST_GAP;
                    cnt_n   = CNT_W'(GAP - 1);
                    line_n  = 1'b1;
                    done_n  = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                line_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State, counters, latched frame and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            rep_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            data_q  <= data_n;
            rep_q   <= rep_n;
            line_q  <= line_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Carrier is enabled from the next line level so its first high cycle
    // coincides with the first low cycle of each mark.
    ir_carrier_gen #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .clk    (clk),
        .rst    (rst),
        .enable (~line_n),
        .carrier(carrier)
    );

    assign bus.ir_line = line_q;
    assign bus.ir_led  = ~line_q & carrier;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx with shortened timing so whole frames fit in
// a short run. Line pulses are measured and decoded back into a data word.
module tb_nec_ir_tx;

    localparam int LM = 20;
    localparam int LS = 10;
    localparam int RS = 6;
    localparam int BM = 6;
    localparam int ZS = 4;
    localparam int OS = 9;
    localparam int GP = 30;
    localparam int CH = 2;
    localparam int LIMIT = 400;

    logic clk = 1'b0;
    logic rst;
    int   checks  = 0;
    int   errors  = 0;
    int   led_bad = 0;

    always #5 clk = ~clk;

    nec_ir_tx_if bus ();

    nec_ir_tx #(
        .LEADER_MARK (LM),
        .LEADER_SPACE(LS),
        .REPEAT_SPACE(RS),
        .BIT_MARK    (BM),
        .ZERO_SPACE  (ZS),
        .ONE_SPACE   (OS),
        .GAP         (GP),
        .CARRIER_HALF(CH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // The LED must never be lit while the line is idle or in a space.
    always @(negedge clk) begin
        if (bus.ir_led === 1'b1 && bus.ir_line !== 1'b0) led_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles the line stays at lvl, with the LED level of each cycle.
    task automatic run_len(input logic lvl, output int len, output logic [31:0] pat);
        len = 0;
        pat = '0;
        while (bus.ir_line === lvl && len < LIMIT) begin
            if (len < 32) pat[len] = bus.ir_led;
            tick();
            len++;
        end
    endtask

    // Measures one transmission starting on its first low cycle.
    task automatic receive(input bit is_rep, output logic [31:0] word,
                           output int lead_mark, output int lead_space,
                           output int total, output int bad_phases,
                           output logic [5:0] first_led);
        int          len;
        logic [31:0] pat;
        word       = '0;
        bad_phases = 0;
        first_led  = '0;
        run_len(1'b0, lead_mark, pat);
        run_len(1'b1, lead_space, pat);
        total = lead_mark + lead_space;
        if (!is_rep) begin
            for (int i = 0; i < 32; i++) begin
                run_len(1'b0, len, pat);
                total += len;
                if (len != BM) bad_phases++;
                if (i == 0) first_led = pat[5:0];
                run_len(1'b1, len, pat);
                total += len;
                if (len == OS) word[i] = 1'b1;
                else if (len != ZS) bad_phases++;
            end
        end
        run_len(1'b0, len, pat);
        total += len;
        if (len != BM) bad_phases++;
    endtask

    // Remaining busy cycles, plus any low line seen meanwhile.
    task automatic gap_len(output int n, output int line_low);
        n = 0;
        line_low = 0;
        while (bus.busy === 1'b1 && n < LIMIT) begin
            if (bus.ir_line !== 1'b1) line_low++;
            tick();
            n++;
        end
    endtask

    // One-cycle start; request fields are scrambled right after accept.
    task automatic send(input logic rep, input logic [15:0] a, input logic [7:0] c);
        bus.address    = a;
        bus.command    = c;
        bus.repeat_req = rep;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.repeat_req = ~rep;
        bus.address    = ~a;
        bus.command    = ~c;
    endtask

    initial begin
        logic [31:0] word;
        logic [5:0]  first_led;
        int          lm, ls, total, bad, n, low;
        logic [15:0] la [3];
        logic [7:0]  lc [3];
        logic [31:0] lw [3];

        la = '{16'h00FF, 16'h1234, 16'hA55A};
        lc = '{8'h1A, 8'h00, 8'h09};
        lw = '{32'hE51A00FF, 32'hFF001234, 32'hF609A55A};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.repeat_req = 1'b0;
        bus.address    = '0;
        bus.command    = '0;
        repeat (3) tick();
        check("reset_line", bus.ir_line, 1);
        check("reset_led",  bus.ir_led,  0);
        check("reset_busy", bus.busy,    0);
        check("reset_done", bus.done,    0);
        rst = 1'b0;
        tick();

        // Abort a frame inside the leader with an asynchronous reset.
        send(1'b0, 16'h1234, 8'h56);
        repeat (10) tick();
        check("mid_lead_low", bus.ir_line, 0);
        #3 rst = 1'b1;
        #1;
        check("abort_line", bus.ir_line, 1);
        check("abort_busy", bus.busy,    0);
        check("abort_led",  bus.ir_led,  0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Full frame, address 0x0000, command 0x12.
        send(1'b0, 16'h0000, 8'h12);
        check("accept_busy",     bus.busy,    1);
        check("accept_line",     bus.ir_line, 0);
        check("accept_led_high", bus.ir_led,  1);
        receive(1'b0, word, lm, ls, total, bad, first_led);
        check("frame_lead_mark",  lm,        LM);
        check("frame_lead_space", ls,        LS);
        check("frame_word",       word,      32'hED120000);
        check("frame_phases",     bad,       0);
        check("frame_bit0_led",   first_led, 6'b110011);
        check("frame_total",      total,     396);
        check("frame_done",       bus.done,  1);
        check("frame_busy_held",  bus.busy,  1);
        tick();
        check("frame_done_once", bus.done, 0);
        gap_len(n, low);
        check("frame_gap_len",  n,   GP - 1);
        check("frame_gap_line", low, 0);

        // Repeat code accepted one cycle after busy fell; a second start
        // ten cycles after accept is ignored.
        send(1'b1, 16'hBEEF, 8'h77);
        check("rep_accept_busy", bus.busy,    1);
        check("rep_accept_line", bus.ir_line, 0);
        repeat (9) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        receive(1'b1, word, lm, ls, total, bad, first_led);
        check("rep_lead_mark",  lm + 10,    LM);
        check("rep_space",      ls,         RS);
        check("rep_phases",     bad,        0);
        check("rep_total",      total + 10, 32);
        check("rep_done",       bus.done,   1);
        tick();
        check("rep_done_once", bus.done, 0);
        repeat (5) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("gap_start_ignored", bus.ir_line, 1);
        gap_len(n, low);
        check("rep_gap_len",  n,   GP - 7);
        check("rep_gap_line", low, 0);

        // Decode several frames back out of the line.
        for (int i = 0; i < 3; i++) begin
            send(1'b0, la[i], lc[i]);
            receive(1'b0, word, lm, ls, total, bad, first_led);
            check($sformatf("loop%0d_word", i),    word,                          lw[i]);
            check($sformatf("loop%0d_cmd", i),     word[23:16],                   lc[i]);
            check($sformatf("loop%0d_inverse", i), word[31:24] ^ word[23:16],     8'hFF);
            check($sformatf("loop%0d_phases", i),  bad,                           0);
            tick();
            gap_len(n, low);
            check($sformatf("loop%0d_gap", i),     n,                             GP - 1);
        end

        check("led_only_in_marks", led_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
